// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction formats, major opcodes,
// immediate ranges and the loader FSM state type.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Signed immediate limits; B and J offsets must also be even.
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -(1 << 20);
  localparam int IMMJ_MAX  = (1 << 20) - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: scatters the immediate into its format-specific
// bit positions and flags encodings that cannot be represented.
// Optional range checking is compiled in with ENC_RANGE_CHECK_EN.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        violation
);

  always_comb begin
    word      = '0;
    violation = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
        violation = !in_range(imm, IMM12_MIN, IMM12_MAX);
`endif
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef ENC_RANGE_CHECK_EN
        violation = !in_range(imm, IMM12_MIN, IMM12_MAX);
`endif
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef ENC_RANGE_CHECK_EN
        violation = !in_range(imm, IMMB_MIN, IMMB_MAX) || imm[0];
`endif
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
        violation = (imm[11:0] != 12'd0);
`endif
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
        violation = !in_range(imm, IMMJ_MIN, IMMJ_MAX) || imm[0];
`endif
      end
      default: violation = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder / IMEM loader: packs field sets and writes them
// to consecutive word addresses. ENC_RANGE_CHECK_EN enables immediate checks.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  err_idx
);

  state_e            state_reg, state_next;
  logic [LEN_W-1:0]  count_reg, len_reg, err_idx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              we_reg, err_reg;
  logic [31:0]       word;
  logic              violation;
  logic              accept, start_ok, write_done;
  logic              unused_base;

  instr_pack u_pack (
    .fmt      (fmt),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .word     (word),
    .violation(violation)
  );

  // Word alignment is forced, so the low base bits never reach the address.
  assign unused_base = ^base[1:0];

  assign in_ready   = (state_reg == ST_RUN) && (!we_reg || mem_ready) && (count_reg < len_reg);
  assign accept     = in_valid && in_ready;
  assign start_ok   = start && (state_reg != ST_RUN);
  assign write_done = we_reg && mem_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (accept && violation)
          state_next = ST_ERR;
        else if (write_done && (count_reg == len_reg))
          state_next = ST_DONE;
      end
      default: begin
        if (start)
          state_next = (len == '0) ? ST_DONE : ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      len_reg     <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      we_reg      <= 1'b0;
      err_reg     <= 1'b0;
      err_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        len_reg     <= len;
        count_reg   <= '0;
        addr_reg    <= {base[ADDR_W-1:2], 2'b00};
        we_reg      <= 1'b0;
        err_reg     <= 1'b0;
        err_idx_reg <= '0;
      end else begin
        if (write_done)
          addr_reg <= addr_reg + ADDR_W'(4);
        // A rejected word leaves its write slot empty.
        if (accept) begin
          if (violation) begin
            we_reg      <= 1'b0;
            err_reg     <= 1'b1;
            err_idx_reg <= count_reg;
          end else begin
            we_reg    <= 1'b1;
            wdata_reg <= word;
            count_reg <= count_reg + LEN_W'(1);
          end
        end else if (mem_ready) begin
          we_reg <= 1'b0;
        end
      end
    end
  end

  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign busy      = (state_reg == ST_RUN);
  assign done      = (state_reg == ST_DONE);
  assign err       = err_reg;
  assign err_idx   = err_idx_reg;

endmodule
